// File: rtl/iq_averager_if.sv
// Sample/strobe inputs and result/debug outputs of one I or Q averaging lane.
interface iq_averager_if #(
  parameter int AMP_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
);
  logic signed [AMP_W-1:0] amplitude;
  logic                    load_val;
  logic                    msf_carrier_pulse;
  logic                    one_sec_marker;
  logic [CNT_W-1:0]        number_msf_periods;
  logic signed [AMP_W-1:0] average;
  logic                    valid;
  logic signed [ACC_W-1:0] accumulator;
  logic [CNT_W-1:0]        counter;

  modport master (
    output amplitude, load_val, msf_carrier_pulse, one_sec_marker, number_msf_periods,
    input  average, valid, accumulator, counter
  );

  modport slave (
    input  amplitude, load_val, msf_carrier_pulse, one_sec_marker, number_msf_periods,
    output average, valid, accumulator, counter
  );
endinterface

// File: rtl/iq_averager.sv
// Windowed mean of a signed amplitude stream over N MSF carrier periods, sequential divide.
// Optional macro AVG_SATURATE_EN: saturating, sticky accumulator that forces a clipped average.
module iq_averager #(
  parameter int AMP_W = 16,
  parameter int ACC_W = 24,
  parameter int CNT_W = 10
) (
  input logic          clk,
  input logic          rst,
  iq_averager_if.slave bus
);
  localparam int STEP_W = $clog2(ACC_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ACC_W - 1);
  localparam logic signed [AMP_W-1:0] AVG_MAX = {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic signed [AMP_W-1:0] AVG_MIN = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] POS_LIM = {{(ACC_W-AMP_W+1){1'b0}}, {(AMP_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NEG_LIM = {{(ACC_W-AMP_W){1'b0}}, 1'b1, {(AMP_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX, S_OUT} div_state_t;

  div_state_t state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_add, amp_ext;
  logic [CNT_W-1:0]        cnt_reg, samp_reg, samp_add;
  logic [CNT_W:0]          cnt_plus1, n_eff;
  logic                    window_end, div_start, div_done;
  logic [ACC_W-1:0]        mag_reg, div_mag;
  logic [CNT_W-1:0]        rem_reg, dvsr_reg, rem_next;
  logic [CNT_W:0]          rem_shift;
  logic                    q_bit, neg_reg, zero_reg, valid_reg;
  logic [STEP_W-1:0]       step_reg;
  logic signed [AMP_W-1:0] res_reg, res_calc, avg_reg;

  assign amp_ext = {{(ACC_W-AMP_W){bus.amplitude[AMP_W-1]}}, bus.amplitude};

`ifdef AVG_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic signed [ACC_W:0] acc_wide;
  logic sat_reg, sat_neg_reg, sat_hit, sat_now, sat_neg_now, sat_lat_reg, sat_neg_lat_reg;

  // Once saturated the accumulator freezes at the extreme until the window is cleared.
  always_comb begin
    acc_wide    = {acc_reg[ACC_W-1], acc_reg} + {amp_ext[ACC_W-1], amp_ext};
    sat_hit     = bus.load_val && !sat_reg && (acc_wide[ACC_W] != acc_wide[ACC_W-1]);
    acc_add     = acc_reg;
    if (sat_hit)
      acc_add = acc_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else if (bus.load_val && !sat_reg)
      acc_add = acc_wide[ACC_W-1:0];
    sat_now     = sat_reg | sat_hit;
    sat_neg_now = sat_hit ? acc_wide[ACC_W] : sat_neg_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_reg         <= 1'b0;
      sat_neg_reg     <= 1'b0;
      sat_lat_reg     <= 1'b0;
      sat_neg_lat_reg <= 1'b0;
    end else begin
      if (bus.one_sec_marker || window_end) begin
        sat_reg     <= 1'b0;
        sat_neg_reg <= 1'b0;
      end else begin
        sat_reg     <= sat_now;
        sat_neg_reg <= sat_neg_now;
      end
      if (div_start) begin
        sat_lat_reg     <= sat_now;
        sat_neg_lat_reg <= sat_neg_now;
      end
    end
  end
`else
  always_comb begin
    acc_add = acc_reg;
    if (bus.load_val)
      acc_add = acc_reg + amp_ext;
  end
`endif

  always_comb begin
    samp_add = samp_reg;
    if (bus.load_val && (samp_reg != {CNT_W{1'b1}}))
      samp_add = samp_reg + CNT_W'(1);
    cnt_plus1  = {1'b0, cnt_reg} + (CNT_W+1)'(1);
    n_eff      = (bus.number_msf_periods == '0) ? (CNT_W+1)'(1) : {1'b0, bus.number_msf_periods};
    window_end = bus.msf_carrier_pulse && (cnt_plus1 >= n_eff);
    div_mag    = acc_add[ACC_W-1] ? -acc_add : acc_add;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      samp_reg <= '0;
    end else if (bus.one_sec_marker || window_end) begin
      acc_reg  <= '0;
      cnt_reg  <= '0;
      samp_reg <= '0;
    end else begin
      acc_reg  <= acc_add;
      samp_reg <= samp_add;
      if (bus.msf_carrier_pulse)
        cnt_reg <= cnt_plus1[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_reg <= S_IDLE;
    else
      state_reg <= state_next;
  end

  // A window ending outside S_IDLE is ignored: the running divide owns the result.
  always_comb begin
    state_next = state_reg;
    div_start  = 1'b0;
    div_done   = 1'b0;
    case (state_reg)
      S_IDLE: if (window_end) begin
        state_next = S_DIV;
        div_start  = 1'b1;
      end
      S_DIV:  if (step_reg == LAST_STEP) state_next = S_FIX;
      S_FIX:  state_next = S_OUT;
      S_OUT: begin
        state_next = S_IDLE;
        div_done   = 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
    if (bus.one_sec_marker) begin
      state_next = S_IDLE;
      div_start  = 1'b0;
      div_done   = 1'b0;
    end
  end

  // Restoring step: remainder never exceeds the divisor, so CNT_W bits hold it.
  always_comb begin
    rem_shift = {rem_reg, mag_reg[ACC_W-1]};
    q_bit     = (rem_shift >= {1'b0, dvsr_reg});
    rem_next  = q_bit ? CNT_W'(rem_shift - {1'b0, dvsr_reg}) : rem_shift[CNT_W-1:0];
  end

  always_comb begin
    res_calc = '0;
    if (zero_reg)
      res_calc = '0;
    else if (!neg_reg)
      res_calc = (mag_reg > POS_LIM) ? AVG_MAX : mag_reg[AMP_W-1:0];
    else
      res_calc = (mag_reg > NEG_LIM) ? AVG_MIN : -mag_reg[AMP_W-1:0];
`ifdef AVG_SATURATE_EN
    if (sat_lat_reg)
      res_calc = sat_neg_lat_reg ? AVG_MIN : AVG_MAX;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mag_reg   <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      neg_reg   <= 1'b0;
      zero_reg  <= 1'b0;
      step_reg  <= '0;
      res_reg   <= '0;
      avg_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= div_done;
      if (div_start) begin
        mag_reg  <= div_mag;
        rem_reg  <= '0;
        dvsr_reg <= samp_add;
        neg_reg  <= acc_add[ACC_W-1];
        zero_reg <= (samp_add == '0);
        step_reg <= '0;
      end else if (state_reg == S_DIV) begin
        rem_reg  <= rem_next;
        mag_reg  <= {mag_reg[ACC_W-2:0], q_bit};
        step_reg <= step_reg + STEP_W'(1);
      end
      if (state_reg == S_FIX)
        res_reg <= res_calc;
      if (div_done)
        avg_reg <= res_reg;
    end
  end

  assign bus.average     = avg_reg;
  assign bus.valid       = valid_reg;
  assign bus.accumulator = acc_reg;
  assign bus.counter     = cnt_reg;
endmodule

// File: tb/tb_iq_averager.sv
// Directed bench for iq_averager: hand-computed window means, latency, resync and reset cases.
`timescale 1ns/1ps
module tb_iq_averager;
  localparam int AMP_W = 16;
  localparam int ACC_W = 24;
  localparam int CNT_W = 10;
`ifdef AVG_SATURATE_EN
  localparam longint WRAP_ACC = 8388607;
  localparam longint WRAP_AVG = 32767;
`else
  localparam longint WRAP_ACC = -6947116;
  localparam longint WRAP_AVG = -23157;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0, n_cmp = 0, n_bad = 0, vcount = 0, vcyc = 0, last_cyc = 0, we = 0;
  logic signed [AMP_W-1:0] vavg = '0;

  iq_averager_if #(.AMP_W(AMP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) io ();
  iq_averager #(.AMP_W(AMP_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (io.valid === 1'b1) begin
      vcount++;
      vavg = io.average;
      vcyc = cyc;
    end
  end

  task automatic check_val(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else
      $display("ok   %s: %0d", tag, obs);
  endtask

  task automatic step(input logic ld, input int amp, input logic car, input logic mk);
    io.load_val          = ld;
    io.amplitude         = AMP_W'(amp);
    io.msf_carrier_pulse = car;
    io.one_sec_marker    = mk;
    @(posedge clk);
    @(negedge clk);
    #1;
    io.load_val          = 1'b0;
    io.msf_carrier_pulse = 1'b0;
    io.one_sec_marker    = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic period(input int loads, input int amp);
    repeat (loads) step(1'b1, amp, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 0, 1'b1, 1'b0);
    we = last_cyc;
  endtask

  task automatic wait_valid(input string tag, input longint exp_avg, input int we_cyc);
    int base = vcount;
    for (int i = 0; i < 40 && vcount == base; i++) idle(1);
    idle(3);
    check_val({tag, "_pulses"}, vcount - base, 1);
    check_val({tag, "_latency"}, vcyc - we_cyc, 26);
    check_val({tag, "_avg"}, vavg, exp_avg);
  endtask

  task automatic no_valid(input string tag, input int n);
    int base = vcount;
    idle(n);
    check_val(tag, vcount - base, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.amplitude = '0;
    io.load_val = 1'b0;
    io.msf_carrier_pulse = 1'b0;
    io.one_sec_marker = 1'b0;
    io.number_msf_periods = CNT_W'(2);
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_acc", io.accumulator, 0);
    check_val("rst_cnt", io.counter, 0);
    check_val("rst_avg", io.average, 0);
    check_val("rst_valid", io.valid, 0);
    rst = 1'b1;
    idle(2);

    // constant 1080, N=2, three samples per period
    period(3, 1080);
    check_val("const_acc_mid", io.accumulator, 3240);
    check_val("const_cnt_mid", io.counter, 1);
    period(3, 1080);
    check_val("const_acc_clr", io.accumulator, 0);
    check_val("const_cnt_clr", io.counter, 0);
    wait_valid("const", 1080, we);

    // step 1080 -> 108: transitional 2376/4, then pure 108
    period(2, 1080);
    period(2, 108);
    wait_valid("step_trans", 594, we);
    period(3, 108);
    period(3, 108);
    wait_valid("step_post", 108, we);

    // negative stream, N=4
    io.number_msf_periods = CNT_W'(4);
    period(1, -500);
    period(1, -500);
    check_val("neg_acc", io.accumulator, -1000);
    check_val("neg_cnt", io.counter, 2);
    period(1, -500);
    period(1, -500);
    wait_valid("neg", -500, we);

    // truncation toward zero: -7/2 -> -3
    io.number_msf_periods = CNT_W'(1);
    step(1'b1, -7, 1'b0, 1'b0);
    step(1'b1, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("trunc", -3, last_cyc);

    // sample in the window-end cycle is included: (5+4)/2 -> 4
    step(1'b1, 5, 1'b0, 1'b0);
    step(1'b1, 4, 1'b1, 1'b0);
    we = last_cyc;
    check_val("same_acc_clr", io.accumulator, 0);
    wait_valid("same", 4, we);

    // no samples in window -> average 0
    io.number_msf_periods = CNT_W'(2);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(2);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("zero", 0, last_cyc);

    // N=0 acts as N=1
    io.number_msf_periods = '0;
    step(1'b1, 10, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("n0", 10, last_cyc);

    // resync mid-window
    io.number_msf_periods = CNT_W'(2);
    step(1'b1, 100, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    check_val("sync_cnt_pre", io.counter, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check_val("sync_cnt", io.counter, 0);
    check_val("sync_acc", io.accumulator, 0);
    step(1'b1, 50, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    check_val("sync_cnt_restart", io.counter, 1);
    no_valid("sync_mid_novalid", 30);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("sync_after", 50, last_cyc);

    // resync during divide aborts the result; marker beats load+carrier
    step(1'b1, 77, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    idle(10);
    step(1'b0, 0, 1'b0, 1'b1);
    no_valid("sync_div_novalid", 40);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 123, 1'b1, 1'b1);
    check_val("prio_acc", io.accumulator, 0);
    check_val("prio_cnt", io.counter, 0);
    no_valid("prio_novalid", 35);

    // window end while divider busy is dropped
    io.number_msf_periods = CNT_W'(1);
    step(1'b1, 200, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    we = last_cyc;
    idle(4);
    step(1'b1, 999, 1'b1, 1'b0);
    check_val("busy_acc_clr", io.accumulator, 0);
    wait_valid("busy", 200, we);
    no_valid("busy_drop", 30);

    // window length shortened mid-window
    io.number_msf_periods = CNT_W'(5);
    step(1'b1, -40, 1'b0, 1'b0);
    repeat (3) step(1'b0, 0, 1'b1, 1'b0);
    check_val("nchg_cnt", io.counter, 3);
    io.number_msf_periods = CNT_W'(2);
    step(1'b0, 0, 1'b1, 1'b0);
    we = last_cyc;
    check_val("nchg_cnt_clr", io.counter, 0);
    wait_valid("nchg", -40, we);

    // sample count saturates at 1023: 2060/1023 -> 2
    io.number_msf_periods = CNT_W'(1);
    repeat (1030) step(1'b1, 2, 1'b0, 1'b0);
    check_val("scnt_acc", io.accumulator, 2060);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("scnt", 2, last_cyc);

    // 300 x 32767 overflows the accumulator
    repeat (300) step(1'b1, 32767, 1'b0, 1'b0);
    check_val("wrap_acc", io.accumulator, WRAP_ACC);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("wrap", WRAP_AVG, last_cyc);

    // async reset mid-window and during a divide
    io.number_msf_periods = CNT_W'(2);
    step(1'b1, 300, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    step(1'b1, 55, 1'b0, 1'b0);
    idle(3);
    rst = 1'b0;
    #1;
    check_val("arst_acc", io.accumulator, 0);
    check_val("arst_cnt", io.counter, 0);
    check_val("arst_avg", io.average, 0);
    check_val("arst_valid", io.valid, 0);
    rst = 1'b1;
    no_valid("arst_novalid", 40);
    step(1'b1, 300, 1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 1'b0);
    check_val("arst_cnt_restart", io.counter, 1);
    step(1'b0, 0, 1'b1, 1'b0);
    wait_valid("arst_after", 300, last_cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
